gfu_issue_sched: RTL and testbench
==================================

GFU_ISSUE_SCHED -- requirements
Module: gfu_issue_sched

Interface
REQ-001 The module SHALL have parameter NUM_FU, default 4, meaning the number of general functional units (FUST_G rows) scheduled.
REQ-002 The module SHALL have parameter LAT_W, default 3, meaning the width of each per-FU latency field.
REQ-003 The module SHALL have parameter WB_DEPTH, default 8, meaning the writeback reservation depth; it SHALL be at least 2^LAT_W.
REQ-004 The module SHALL use a single clock, and its reset SHALL be asynchronous and active-low.
REQ-005 CLK  input  1  clock; all state updates on the rising edge.
REQ-006 nRST  input  1  asynchronous active-low reset.
REQ-007 req  input  NUM_FU  per-FU request: the FUST_G row is valid and its operands are ready.
REQ-008 fu_lat  input  NUM_FU*LAT_W  per-FU execute latency in cycles, static configuration; value 0 is treated as 1.
REQ-009 fu_done  input  NUM_FU  single-cycle pulse: the FU completed and is free.
REQ-010 stall  input  1  issue stall from downstream.
REQ-011 flush  input  1  pipeline flush.
REQ-012 grant  output  NUM_FU  one-hot issue grant, combinational in the request cycle.
REQ-013 grant_valid  output  1  high iff grant is non-zero.
REQ-014 fu_busy  output  NUM_FU  registered per-FU occupancy; drives the busy input of the FUST_G.
REQ-015 wb_valid  output  1  writeback slot owned this cycle.
REQ-016 wb_sel  output  clog2(NUM_FU)  index of the FU owning the writeback port; 0 when wb_valid is low.

Function
REQ-017 The module SHALL compute eligible[i] = req[i] & ~fu_busy[i] & ~res_valid[L_i], where L_i is the effective latency of FU i (1..2^LAT_W-1).
REQ-018 Busy SHALL NOT be bypassed: an FU with fu_busy=1 and fu_done=1 in the same cycle SHALL NOT be eligible in that cycle.
REQ-019 When stall=0 and flush=0, the module SHALL grant at most one eligible FU per cycle.
REQ-020 Grant selection SHALL be round-robin: search starts at rr_ptr and increases modulo NUM_FU.
REQ-021 On a grant to FU k, rr_ptr SHALL become (k+1) mod NUM_FU at the next edge; without a grant, rr_ptr SHALL hold.
REQ-022 When stall=1 or flush=1, grant SHALL be 0 and grant_valid SHALL be 0.
REQ-023 On a grant to FU k, fu_busy[k] SHALL be 1 from the next cycle until the cycle after fu_done[k] is pulsed.
REQ-024 fu_done[i] while fu_busy[i]=0 SHALL be ignored.
REQ-025 The reservation table SHALL hold entries res[0..WB_DEPTH-1], each containing a valid bit and an FU id.
REQ-026 Each cycle, the reservation table SHALL shift down by one: res[j] <= res[j+1], and the top entry SHALL fill with invalid.
REQ-027 A grant to FU k with latency L SHALL write {1,k} into the post-shift res[L-1].
REQ-028 As a result of REQ-027, wb_valid=1 with wb_sel=k SHALL occur exactly L cycles after the grant cycle.
REQ-029 wb_valid and wb_sel SHALL be driven from res[0], registered.
REQ-030 Two grants SHALL never reserve the same writeback cycle; this is guaranteed by REQ-017.
REQ-031 Reservations SHALL continue shifting during stall.
REQ-032 Busy clearing by fu_done SHALL continue during stall.
REQ-033 When flush=1, the next state SHALL be: all res valid bits 0, all fu_busy bits 0, rr_ptr held, and fu_done ignored.
REQ-034 When flush=1, wb_valid SHALL still reflect the current res[0] in the flush cycle.

Reset
REQ-035 While nRST=0, regardless of CLK: fu_busy=0, all res entries invalid, rr_ptr=0, wb_valid=0, wb_sel=0.
REQ-036 While nRST=0, grant=0 and grant_valid=0.
REQ-037 Reset asserted mid-operation SHALL discard all outstanding reservations with no writeback pulse.

Verification
REQ-038 Scenario: reset, then req=4'b1111 with all latencies 2 -> grants FU0, then FU1 in the next cycle (FU0 now busy, slot distinct); wb_valid in cycles t+2 (sel 0) and t+3 (sel 1).
REQ-039 Scenario: FU0 latency 3 granted at cycle t; FU1 latency 2 requesting at t+1 -> FU1 blocked at t+1 (slot t+3 taken); FU1 granted at t+2; wb sel 0 at t+3, sel 1 at t+4.
REQ-040 Scenario: fu_busy[2]=1 with fu_done[2]=1 and req[2]=1 in the same cycle -> no grant to FU2 that cycle; grant to FU2 in the next cycle.
REQ-041 Scenario: stall=1 for 3 cycles with a pending grant at latency 4 -> grant_valid=0 throughout; the earlier reservation still yields wb_valid on its original cycle.
REQ-042 Scenario: flush or nRST=0 with 3 outstanding reservations and 2 busy FUs -> fu_busy=0 the next cycle; no further wb_valid pulses; rr_ptr retained (flush) or reset to 0 (reset).
REQ-043 Scenario: req stuck at 4'b1111 with immediate fu_done -> grants rotate 0,1,2,3,0; no FU is starved.

Source files
------------

// File: rtl/gfu_issue_sched.sv
// Issue scheduler for the general functional units: round-robin grant among
// eligible FUs, per-FU busy tracking and a shifting writeback reservation table.
module gfu_issue_sched #(
  parameter int unsigned NUM_FU   = 4,
  parameter int unsigned LAT_W    = 3,
  parameter int unsigned WB_DEPTH = 8,
  localparam int unsigned SEL_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NUM_FU-1:0]       req,
  input  logic [NUM_FU*LAT_W-1:0] fu_lat,
  input  logic [NUM_FU-1:0]       fu_done,
  input  logic                    stall,
  input  logic                    flush,
  output logic [NUM_FU-1:0]       grant,
  output logic                    grant_valid,
  output logic [NUM_FU-1:0]       fu_busy,
  output logic                    wb_valid,
  output logic [SEL_W-1:0]        wb_sel
);

  localparam int unsigned RES_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

  logic [NUM_FU-1:0]   busy_q, busy_d;
  logic [WB_DEPTH-1:0] res_v_q, res_v_d;
  logic [SEL_W-1:0]    res_id_q [WB_DEPTH];
  logic [SEL_W-1:0]    res_id_d [WB_DEPTH];
  logic [SEL_W-1:0]    rr_q, rr_d;

  logic [LAT_W-1:0]    lat_eff [NUM_FU];
  logic [NUM_FU-1:0]   eligible;
  logic [SEL_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic                gnt_v;
  logic [RES_W-1:0]    ins_idx;

  // Eligibility looks at res[L], which becomes res[L-1] after this edge's shift.
  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      lat_eff[i] = fu_lat[i*LAT_W +: LAT_W];
      if (lat_eff[i] == '0) lat_eff[i] = LAT_W'(1);
      eligible[i] = req[i] & ~busy_q[i] & ~res_v_q[RES_W'(lat_eff[i])];
    end
  end

  always_comb begin
    int unsigned idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      idx = (32'(rr_q) + off) % NUM_FU;
      if (!gnt_any && eligible[idx[SEL_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[SEL_W-1:0];
      end
    end
    gnt_v = gnt_any & ~stall & ~flush & nRST;
    grant = '0;
    if (gnt_v) grant[gnt_idx] = 1'b1;
    ins_idx = RES_W'(lat_eff[gnt_idx]) - RES_W'(1);
  end

  always_comb begin
    res_v_d = {1'b0, res_v_q[WB_DEPTH-1:1]};
    for (int unsigned j = 0; j < WB_DEPTH - 1; j++) res_id_d[j] = res_id_q[j+1];
    res_id_d[WB_DEPTH-1] = '0;
    if (gnt_v) begin
      res_v_d[ins_idx]  = 1'b1;
      res_id_d[ins_idx] = gnt_idx;
    end
    busy_d = (busy_q & ~fu_done) | grant;
    rr_d   = rr_q;
    if (gnt_v) rr_d = (gnt_idx == SEL_W'(NUM_FU - 1)) ? '0 : gnt_idx + SEL_W'(1);
    if (flush) begin
      res_v_d = '0;
      busy_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q  <= '0;
      res_v_q <= '0;
      rr_q    <= '0;
      for (int unsigned j = 0; j < WB_DEPTH; j++) res_id_q[j] <= '0;
    end else begin
      busy_q  <= busy_d;
      res_v_q <= res_v_d;
      rr_q    <= rr_d;
      for (int unsigned j = 0; j < WB_DEPTH; j++) res_id_q[j] <= res_id_d[j];
    end
  end

  assign grant_valid = gnt_v;
  assign fu_busy     = busy_q;
  assign wb_valid    = res_v_q[0];
  assign wb_sel      = res_v_q[0] ? res_id_q[0] : '0;

endmodule

// File: tb/tb_gfu_issue_sched.sv
// Directed bench for gfu_issue_sched: stimulus pushes expected grants and
// writebacks (stamped with their cycle) into queues; a negedge monitor checks them.
module tb_gfu_issue_sched;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  req, fu_done, grant, fu_busy;
  logic [11:0] fu_lat;
  logic        stall, flush, grant_valid, wb_valid;
  logic [1:0]  wb_sel;

  gfu_issue_sched #(.NUM_FU(4), .LAT_W(3), .WB_DEPTH(8)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .fu_lat(fu_lat), .fu_done(fu_done),
    .stall(stall), .flush(flush), .grant(grant), .grant_valid(grant_valid),
    .fu_busy(fu_busy), .wb_valid(wb_valid), .wb_sel(wb_sel)
  );

  always #5 CLK = ~CLK;

  typedef struct { int unsigned cyc; int val; } exp_t;
  exp_t gq[$];
  exp_t wq[$];

  int unsigned cyc = 0;
  int total = 0;
  int bad   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (nRST) begin
      chk("grant_valid_vs_grant", grant_valid, grant != 4'b0);
      if (gq.size() != 0 && gq[0].cyc == cyc) begin
        e = gq.pop_front();
        chk("grant", grant, e.val);
      end else begin
        chk("grant_idle", grant, 0);
      end
      if (wq.size() != 0 && wq[0].cyc == cyc) begin
        e = wq.pop_front();
        chk("wb_valid", wb_valid, 1);
        chk("wb_sel", wb_sel, e.val);
      end else begin
        chk("wb_valid_idle", wb_valid, 0);
        chk("wb_sel_idle", wb_sel, 0);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic eg(input int k, input int lat, input bit with_wb);
    gq.push_back('{cyc, 1 << k});
    if (with_wb) wq.push_back('{cyc + lat, k});
  endtask

  function automatic logic [11:0] lat4(input int l3, input int l2, input int l1, input int l0);
    return {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; req = 4'hF; fu_done = '0; stall = 1'b0; flush = 1'b0;
    fu_lat = lat4(2, 2, 2, 2);
    #1;
    chk("rst_busy", fu_busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_grant", grant, 0);
    chk("rst_grant_valid", grant_valid, 0);
    step(); step();
    nRST = 1'b1; req = '0;
    step();

    // two grants back to back, all latencies 2
    req = 4'hF; eg(0, 2, 1); step();
    chk("s1_busy", fu_busy, 4'b0001);
    eg(1, 2, 1); step();
    req = '0; fu_done = 4'b0011; step();
    fu_done = '0;
    chk("s1_busy_clear", fu_busy, 0);
    step(); step();

    // slot conflict: FU0 lat 3 then FU1 lat 2 is blocked one cycle
    fu_lat = lat4(2, 2, 2, 3);
    req = 4'b0001; eg(0, 3, 1); step();
    req = 4'b0010; step();
    eg(1, 2, 1); step();
    req = '0; fu_done = 4'b0011; step();
    fu_done = '0; step(); step(); step();

    // busy is not bypassed by a same-cycle done; latency 0 acts as 1
    fu_lat = lat4(1, 0, 1, 1);
    req = 4'b0100; eg(2, 1, 1); step();
    chk("s3_busy", fu_busy, 4'b0100);
    fu_done = 4'b0100; step();
    fu_done = '0; eg(2, 1, 1); step();
    req = '0; fu_done = 4'b0100; step();
    fu_done = '0; step();

    // stall blocks grants but reservations and busy clearing continue
    fu_lat = lat4(4, 1, 1, 1);
    req = 4'b1000; eg(3, 4, 1); step();
    stall = 1'b1; req = 4'hF; step();
    fu_done = 4'b1000; step();
    fu_done = '0;
    chk("s4_busy_clear_in_stall", fu_busy, 0);
    step();
    stall = 1'b0; req = 4'b0001; eg(0, 1, 1); step();
    req = '0; fu_done = 4'b0001; step();
    fu_done = '0; step(); step();

    // flush drops 3 reservations and 2 busy FUs, keeps rr_ptr
    fu_lat = lat4(7, 6, 1, 3);
    req = 4'b0100; eg(2, 6, 0); step();
    req = 4'b1000; fu_done = 4'b0100; eg(3, 7, 0); step();
    req = 4'b0001; fu_done = '0; eg(0, 3, 0); step();
    chk("s5_busy_before_flush", fu_busy, 4'b1001);
    flush = 1'b1; req = 4'hF; fu_done = 4'b1001; step();
    flush = 1'b0; req = '0; fu_done = '0;
    chk("s5_busy_after_flush", fu_busy, 0);
    repeat (8) step();
    req = 4'hF; eg(1, 1, 1); step();
    req = '0; fu_done = 4'b0010; step();
    fu_done = '0; step();

    // reset mid-operation discards the pending writeback and rr_ptr
    fu_lat = lat4(1, 6, 1, 1);
    req = 4'b0100; eg(2, 6, 0); step();
    nRST = 1'b0; req = 4'hF;
    #1;
    chk("s6_rst_busy", fu_busy, 0);
    chk("s6_rst_wb_valid", wb_valid, 0);
    chk("s6_rst_grant", grant, 0);
    chk("s6_rst_grant_valid", grant_valid, 0);
    step(); step();
    nRST = 1'b1; req = '0;
    repeat (8) step();

    // rotation with immediate completion: 0,1,2,3,0
    fu_lat = lat4(1, 1, 1, 1);
    req = 4'hF; eg(0, 1, 1); step();
    fu_done = 4'b0001; eg(1, 1, 1); step();
    fu_done = 4'b0010; eg(2, 1, 1); step();
    fu_done = 4'b0100; eg(3, 1, 1); step();
    fu_done = 4'b1000; eg(0, 1, 1); step();
    req = '0; fu_done = 4'b0001; step();
    fu_done = '0; step(); step(); step();

    chk("grant_queue_drained", gq.size(), 0);
    chk("wb_queue_drained", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
